// File: rtl/meissa_pkg.sv
// ----------------------------------------------------------------------------
// meissa_pkg
// Shared constants and types for the meissa dot-product sequencer slice.
//   DEF_*_WIDTH : default widths used as parameter defaults by the modules
//   PE_LAT      : cycles from a buffer read strobe to the matching PE product
//                 (one buffer read cycle + one PE register stage)
//   seq_state_t : sequencer FSM state encoding
// ----------------------------------------------------------------------------
package meissa_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_MAC_WIDTH  = 2 * DEF_DATA_WIDTH;
    localparam int DEF_ACC_WIDTH  = 40;
    localparam int DEF_ADDR_WIDTH = 9;

    // Drain length and valid-pipe depth both follow from this.
    localparam int PE_LAT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/meissa_addr_gen.sv
// ----------------------------------------------------------------------------
// meissa_addr_gen
// Read-address generator for one operand buffer. Captures a base address and
// job length, then walks base+i (wrapping modulo 2^ADDR_WIDTH) one step per
// advance pulse.
//   clk, reset : clock, asynchronous active-low reset
//   load       : capture base/len, restart the issue counter at 0
//   advance    : step to the next address
//   base, len  : job base address and number of reads
//   rd_addr    : registered read address
//   last       : the address currently presented is the final one of the job
// ----------------------------------------------------------------------------
module meissa_addr_gen
    import meissa_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  advance,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH:0]   len,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  last
);

    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   cnt;
    logic [ADDR_WIDTH:0]   cnt_next;

    // The counter is one bit wider than the address so a full 2^ADDR_WIDTH
    // job can be counted; the address itself simply wraps.
    assign cnt_next = cnt + (ADDR_WIDTH+1)'(1);
    assign last     = (cnt_next == len_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q  <= '0;
            len_q   <= '0;
            cnt     <= '0;
            rd_addr <= '0;
        end else if (load) begin
            base_q  <= base;
            len_q   <= len;
            cnt     <= '0;
            rd_addr <= base;
        end else if (advance) begin
            cnt     <= cnt_next;
            rd_addr <= base_q + cnt_next[ADDR_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/meissa_pe_seq.sv
// ----------------------------------------------------------------------------
// meissa_pe_seq
// Runs one dot-product job on an external meissa_pe stage: streams operand
// read pairs from the activation/weight buffers, accumulates the PE's
// registered products and returns the sum on a valid/ready port.
//   clk, reset             : clock, asynchronous active-low reset
//   start, base_a, base_w,
//   len                    : job request (sampled only while idle)
//   busy                   : high whenever a job is in progress
//   a_rd_en/a_rd_addr,
//   w_rd_en/w_rd_addr      : registered buffer read strobes and addresses
//   pe_maccout             : signed PE product, valid PE_LAT cycles after a read
//   res_valid/res_ready/
//   res_data               : result handshake and accumulated sum
// ----------------------------------------------------------------------------
module meissa_pe_seq
    import meissa_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAC_WIDTH  = DATA_WIDTH * 2,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_a,
    input  logic [ADDR_WIDTH-1:0] base_w,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  a_rd_en,
    output logic                  w_rd_en,
    output logic [ADDR_WIDTH-1:0] a_rd_addr,
    output logic [ADDR_WIDTH-1:0] w_rd_addr,
    input  logic [MAC_WIDTH-1:0]  pe_maccout,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ACC_WIDTH-1:0]  res_data
);

    localparam int DRAIN_W = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PE_LAT - 1);

    seq_state_t           state;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic [PE_LAT-1:0]    vpipe;
    logic [ACC_WIDTH-1:0] acc;
    logic                 acc_en;
    logic                 accept;
    logic                 advance;
    logic                 a_last;
    logic                 w_last;
    logic                 issue_last;
    logic [ACC_WIDTH-1:0] mac_ext;

    assign accept     = (state == ST_IDLE) && start;
    assign issue_last = a_last && w_last;
    assign advance    = (state == ST_ISSUE) && !issue_last;
    assign acc_en     = vpipe[PE_LAT-1];
    assign mac_ext    = {{(ACC_WIDTH-MAC_WIDTH){pe_maccout[MAC_WIDTH-1]}}, pe_maccout};
    assign res_data   = acc;

    meissa_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_a (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .advance (advance),
        .base    (base_a),
        .len     (len),
        .rd_addr (a_rd_addr),
        .last    (a_last)
    );

    meissa_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_w (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .advance (advance),
        .base    (base_w),
        .len     (len),
        .rd_addr (w_rd_addr),
        .last    (w_last)
    );

    // Control FSM. All handshake-facing outputs are registered here so they
    // change cleanly on the state transitions. A zero-length job skips
    // straight to DONE with the freshly cleared accumulator as its result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            a_rd_en   <= 1'b0;
            w_rd_en   <= 1'b0;
            res_valid <= 1'b0;
            drain_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        drain_cnt <= '0;
                        if (len != '0) begin
                            state   <= ST_ISSUE;
                            a_rd_en <= 1'b1;
                            w_rd_en <= 1'b1;
                        end else begin
                            state     <= ST_DONE;
                            res_valid <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (issue_last) begin
                        state   <= ST_DRAIN;
                        a_rd_en <= 1'b0;
                        w_rd_en <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // Wait out the buffer + PE latency so the final products
                    // land in the accumulator before the result is offered.
                    if (drain_cnt == DRAIN_LAST) begin
                        state     <= ST_DONE;
                        res_valid <= 1'b1;
                        drain_cnt <= '0;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state     <= ST_IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Datapath: the valid pipe delays each read strobe by PE_LAT cycles so
    // acc_en lines up with the product of that read. The accumulator wraps
    // silently; it is cleared when a new job is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vpipe <= '0;
            acc   <= '0;
        end else begin
            vpipe <= {vpipe[PE_LAT-2:0], a_rd_en};
            if (accept) begin
                acc <= '0;
            end else if (acc_en) begin
                acc <= acc + mac_ext;
            end
        end
    end

endmodule
